// File: rtl/pe_weight_pkg.sv
// Shared definitions for the per-PE weight buffer (loader and circular read side).
package pe_weight_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_ROWS       = 8;
  localparam int unsigned DEF_COLS       = 8;
  localparam int unsigned DEF_STREAM_LEN = 1024;

  localparam logic BANK_MU  = 1'b0;
  localparam logic BANK_VAR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MU,
    LOAD_VAR,
    CHK_MU,
    CHK_VAR,
    DONE
  } state_t;

  // States in which the loader accepts stream words.
  function automatic logic is_xfer_state(input state_t s);
    return (s == LOAD_MU) || (s == LOAD_VAR) || (s == CHK_MU) || (s == CHK_VAR);
  endfunction

endpackage

// File: rtl/pe_weight_loader_if.sv
// Stream input handshake plus bank write strobes of the weight loader.
interface pe_weight_loader_if
  import pe_weight_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROW_W  = $clog2(DEF_ROWS),
  parameter int unsigned COL_W  = $clog2(DEF_COLS)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic              wr_bank;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [DATA_W-1:0] wr_data;

  // Stream producer / bank owner side.
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_bank, wr_row, wr_col, wr_data
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_bank, wr_row, wr_col, wr_data
  );

endinterface

// File: rtl/pe_weight_window.sv
// Window compare of the stream index and its split into bank row/column.
module pe_weight_window
  import pe_weight_pkg::*;
#(
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROW_W     = $clog2(ROWS),
  parameter int unsigned COL_W     = $clog2(COLS)
) (
  input  logic [IDX_W-1:0] idx,
  output logic             hit_c,
  output logic [ROW_W-1:0] row_c,
  output logic [COL_W-1:0] col_c
);

  localparam int unsigned WIN   = ROWS * COLS;
  localparam int unsigned OFF_W = ROW_W + COL_W;

  logic [IDX_W:0]   diff;
  logic [OFF_W-1:0] off;

  // One extra bit makes indices below the window wrap far above it, so a
  // single unsigned compare covers both bounds.
  always_comb begin
    diff  = {1'b0, idx} - (IDX_W+1)'(BASE_ADDR);
    hit_c = diff < (IDX_W+1)'(WIN);
    off   = OFF_W'(diff);
    row_c = off[COL_W +: ROW_W];
    col_c = off[COL_W-1:0];
  end

endmodule

// File: rtl/pe_weight_loader.sv
// Serial mu/var weight stream loader for one PE buffer.
// Optional trailer checksum per bank: define PE_WEIGHT_LOADER_CHECKSUM_EN.
module pe_weight_loader
  import pe_weight_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned STREAM_LEN = DEF_STREAM_LEN,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  pe_weight_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                mu_loaded,
  output logic                var_loaded,
  output logic                chk_err
);

  localparam int unsigned IDX_W = $clog2(STREAM_LEN);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STREAM_LEN - 1);

  if (BASE_ADDR + ROWS * COLS > STREAM_LEN) begin : g_bad_cfg
    $error("pe_weight_loader: BASE_ADDR window runs past STREAM_LEN");
  end

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              mu_loaded_q;
  logic              var_loaded_q;
  logic              wr_en_q;
  logic              wr_bank_q;
  logic [ROW_W-1:0]  wr_row_q;
  logic [COL_W-1:0]  wr_col_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              start_c;
  logic              xfer_c;
  logic              in_load_c;
  logic              last_c;
  logic              keep_c;
  logic              hit_c;
  logic [ROW_W-1:0]  row_c;
  logic [COL_W-1:0]  col_c;

  pe_weight_window #(
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) u_window (
    .idx   (idx),
    .hit_c (hit_c),
    .row_c (row_c),
    .col_c (col_c)
  );

  // Handshake and window qualifiers for the current cycle.
  always_comb begin
    start_c   = start && ((state == IDLE) || (state == DONE));
    xfer_c    = bus.in_valid && in_ready_q;
    in_load_c = (state == LOAD_MU) || (state == LOAD_VAR);
    last_c    = (idx == LAST_IDX);
    keep_c    = xfer_c && in_load_c && hit_c;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the mu->var handover has no idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_c) state_nxt = LOAD_MU;
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
      LOAD_MU:    if (xfer_c && last_c) state_nxt = CHK_MU;
      CHK_MU:     if (xfer_c)           state_nxt = LOAD_VAR;
      LOAD_VAR:   if (xfer_c && last_c) state_nxt = CHK_VAR;
      CHK_VAR:    if (xfer_c)           state_nxt = DONE;
`else
      LOAD_MU:    if (xfer_c && last_c) state_nxt = LOAD_VAR;
      LOAD_VAR:   if (xfer_c && last_c) state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      in_ready_q <= is_xfer_state(state_nxt);
      busy_q     <= (state_nxt != IDLE) && (state_nxt != DONE);
    end
  end

  // Stream index and sticky completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      done_q       <= 1'b0;
      mu_loaded_q  <= 1'b0;
      var_loaded_q <= 1'b0;
    end else if (start_c) begin
      idx          <= '0;
      done_q       <= 1'b0;
      mu_loaded_q  <= 1'b0;
      var_loaded_q <= 1'b0;
    end else begin
      if (xfer_c && in_load_c) idx <= last_c ? '0 : idx + IDX_W'(1);
      if (xfer_c && last_c && (state == LOAD_MU))  mu_loaded_q  <= 1'b1;
      if (xfer_c && last_c && (state == LOAD_VAR)) var_loaded_q <= 1'b1;
      if ((state_nxt == DONE) && (state != DONE))  done_q       <= 1'b1;
    end
  end

  // Bank write strobe, one cycle after each kept transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_bank_q <= BANK_MU;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= keep_c;
      if (keep_c) begin
        wr_bank_q <= (state == LOAD_VAR) ? BANK_VAR : BANK_MU;
        wr_row_q  <= row_c;
        wr_col_q  <= col_c;
        wr_data_q <= bus.in_data;
      end
    end
  end

`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              chk_err_q;

  // Per-bank modulo sum of kept words, compared against the trailer word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (start_c || (xfer_c && (state == CHK_MU))) sum_q <= '0;
      else if (keep_c)                               sum_q <= sum_q + bus.in_data;
      if (start_c) chk_err_q <= 1'b0;
      else if (xfer_c && ((state == CHK_MU) || (state == CHK_VAR)) && (bus.in_data != sum_q))
        chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mu_loaded    = mu_loaded_q;
  assign var_loaded   = var_loaded_q;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed bench for pe_weight_loader: two instances (BASE_ADDR 0 and 64) share
// one stimulus; a cycle model of the stream predicts every strobe and flag.
module tb_pe_weight_loader;

  localparam int STREAM_LEN = 1024;
  localparam int BASE0      = 0;
  localparam int BASE1      = 64;
  localparam int LIMIT      = 20000;
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int SEG = STREAM_LEN + CHK;

  logic clk;
  logic rst;
  logic start;
  logic busy0, done0, mu0, var0, chk0;
  logic busy1, done1, mu1, var1, chk1;

  pe_weight_loader_if bus0 ();
  pe_weight_loader_if bus1 ();

  pe_weight_loader #(.BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(bus0),
    .busy(busy0), .done(done0), .mu_loaded(mu0), .var_loaded(var0), .chk_err(chk0)
  );

  pe_weight_loader #(.BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .busy(busy1), .done(done1), .mu_loaded(mu1), .var_loaded(var1), .chk_err(chk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Stream model state.
  logic        m_busy, m_done, m_mu, m_var;
  logic        m_chk  [2];
  logic        exp_en [2];
  logic [22:0] exp_wr [2];
  logic [15:0] sum    [2];
  int          cnt    [2];
  int          p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_data(input logic bank, input int k, input int mode);
    if (k >= STREAM_LEN) return (mode == 1) ? (bank ? 16'h0041 : 16'h0040) : 16'h0000;
    if (mode == 1) return 16'h0001;
    return bank ? 16'(32'h8000 + k) : 16'(k);
  endfunction

  task automatic reset_model();
    m_busy = 1'b0; m_done = 1'b0; m_mu = 1'b0; m_var = 1'b0;
    m_chk  = '{1'b0, 1'b0};
    exp_en = '{1'b0, 1'b0};
    sum    = '{16'h0, 16'h0};
    p      = 0;
  endtask

  task automatic chk_dut(input string s, input int j, input logic en, input logic [22:0] wr,
                         input logic bsy, input logic rdy, input logic dn, input logic mu,
                         input logic vr, input logic ce);
    check({"wr_en", s}, 32'(en), 32'(exp_en[j]));
    if (exp_en[j]) check({"wr", s}, 32'(wr), 32'(exp_wr[j]));
    check({"busy", s},       32'(bsy), 32'(m_busy));
    check({"in_ready", s},   32'(rdy), 32'(m_busy));
    check({"done", s},       32'(dn),  32'(m_done));
    check({"mu_loaded", s},  32'(mu),  32'(m_mu));
    check({"var_loaded", s}, 32'(vr),  32'(m_var));
    check({"chk_err", s},    32'(ce),  32'(m_chk[j]));
    if (en) cnt[j]++;
  endtask

  task automatic check_all();
    chk_dut("0", 0, bus0.wr_en, {bus0.wr_bank, bus0.wr_row, bus0.wr_col, bus0.wr_data},
            busy0, bus0.in_ready, done0, mu0, var0, chk0);
    chk_dut("1", 1, bus1.wr_en, {bus1.wr_bank, bus1.wr_row, bus1.wr_col, bus1.wr_data},
            busy1, bus1.in_ready, done1, mu1, var1, chk1);
  endtask

  // Apply one cycle of inputs at the falling edge, advance the model, check after the edge.
  task automatic tick(input logic st, input logic vld, input int mode);
    logic        bank;
    int          k;
    int          base;
    logic [15:0] d;
    bank = (p >= SEG);
    k    = bank ? p - SEG : p;
    d    = word_data(bank, k, mode);
    start         = st;
    bus0.in_valid = vld;
    bus1.in_valid = vld;
    bus0.in_data  = vld ? d : 16'hDEAD;
    bus1.in_data  = vld ? d : 16'hDEAD;
    exp_en = '{1'b0, 1'b0};
    if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_done = 1'b0; m_mu = 1'b0; m_var = 1'b0;
        m_chk = '{1'b0, 1'b0};
        sum   = '{16'h0, 16'h0};
        p     = 0;
      end
    end else if (vld) begin
      for (int j = 0; j < 2; j++) begin
        base = (j == 0) ? BASE0 : BASE1;
        if (k < STREAM_LEN) begin
          if (k >= base && k < base + 64) begin
            exp_en[j] = 1'b1;
            exp_wr[j] = {bank, 3'((k - base) / 8), 3'((k - base) % 8), d};
            sum[j]    = sum[j] + d;
          end
        end else begin
          if (d != sum[j]) m_chk[j] = 1'b1;
          sum[j] = 16'h0;
        end
      end
      if (k == STREAM_LEN - 1) begin
        if (!bank) m_mu = 1'b1;
        else       m_var = 1'b1;
        if (CHK == 0) sum = '{16'h0, 16'h0};
      end
      if (p == 2 * SEG - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      p++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // One full load (or partial when abort_at >= 0); start_at re-pulses start mid-load.
  task automatic run_load(input int mode, input int bubble, input int abort_at, input int start_at);
    int   cyc;
    logic vld;
    cnt = '{0, 0};
    tick(1'b1, 1'b0, mode);
    cyc = 0;
    while (m_busy && cyc < LIMIT) begin
      if (abort_at >= 0 && p == abort_at) break;
      vld = (bubble == 0) || (int'($urandom_range(99)) >= bubble);
      tick((start_at >= 0 && p == start_at) ? 1'b1 : 1'b0, vld, mode);
      cyc++;
    end
    if (cyc >= LIMIT) check("timeout", 32'd1, 32'd0);
    if (abort_at < 0) begin
      check("strobes0", 32'(cnt[0]), 32'd128);
      check("strobes1", 32'(cnt[1]), 32'd128);
      tick(1'b0, 1'b0, mode);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus0.in_data  = 16'h0; bus1.in_data  = 16'h0;
    reset_model();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    tick(1'b0, 1'b0, 0);

    // Continuous stream, k / 0x8000+k data.
    run_load(0, 0, -1, -1);
    // Same stream with 50% valid bubbles.
    run_load(0, 50, -1, -1);
    // Reset after 300 mu transfers, then reload.
    run_load(0, 0, 300, -1);
    rst = 1'b1;
    #1;
    reset_model();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    run_load(0, 0, -1, -1);
    // start pulsed while busy at transfer 10 is ignored.
    run_load(0, 0, -1, 10);
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
    // Kept words all 1: mu trailer matches, var trailer is off by one.
    run_load(1, 0, -1, -1);
    check("chk_err_final", 32'(chk0), 32'd1);
    check("done_final",    32'(done0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
